// File: rtl/otter_exec_unit_if.sv
`default_nettype none
// ============================================================================
//  otter_exec_unit_if
//  Bundles the execute-stage operands, controls and results of otter_exec_unit.
//  Revision: 1.0
// ============================================================================
interface otter_exec_unit_if;
  logic        EN;
  logic [3:0]  ALU_FUN;
  logic [31:0] SRC_A;
  logic [31:0] SRC_B;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic [31:0] PC;
  logic [31:0] I_IMM;
  logic [31:0] B_IMM;
  logic [31:0] J_IMM;
  logic [31:0] RESULT;
  logic [31:0] RESULT_Q;
  logic [31:0] JAL;
  logic [31:0] JALR;
  logic [31:0] BRANCH;
  logic        BR_EQ;
  logic        BR_LT;
  logic        BR_LTU;

  modport master (
    output EN, ALU_FUN, SRC_A, SRC_B, RS1, RS2, PC, I_IMM, B_IMM, J_IMM,
    input  RESULT, RESULT_Q, JAL, JALR, BRANCH, BR_EQ, BR_LT, BR_LTU
  );

  modport slave (
    input  EN, ALU_FUN, SRC_A, SRC_B, RS1, RS2, PC, I_IMM, B_IMM, J_IMM,
    output RESULT, RESULT_Q, JAL, JALR, BRANCH, BR_EQ, BR_LT, BR_LTU
  );
endinterface
`default_nettype wire

// File: rtl/otter_exec_unit.sv
`default_nettype none
// ============================================================================
//  otter_exec_unit
//  RV32I execute stage: ALU, branch address and branch condition generators,
//  plus a falling-edge registered copy of the ALU result.
//  Revision: 1.0
// ============================================================================
module otter_exec_unit (
  input  wire logic          CLK,
  input  wire logic          RST,
  otter_exec_unit_if.slave   bus
);

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b1000;
  localparam logic [3:0] c_ALU_SLL  = 4'b0001;
  localparam logic [3:0] c_ALU_SLT  = 4'b0010;
  localparam logic [3:0] c_ALU_SLTU = 4'b0011;
  localparam logic [3:0] c_ALU_XOR  = 4'b0100;
  localparam logic [3:0] c_ALU_SRL  = 4'b0101;
  localparam logic [3:0] c_ALU_SRA  = 4'b1101;
  localparam logic [3:0] c_ALU_OR   = 4'b0110;
  localparam logic [3:0] c_ALU_AND  = 4'b0111;
  localparam logic [3:0] c_ALU_LUI  = 4'b1001;

  logic [4:0]  w_shamt;
  logic [31:0] w_result;
  logic [31:0] w_jalr_sum;
  logic [31:0] r_result_q;

  assign w_shamt = bus.SRC_B[4:0];

  always_comb begin
    w_result = 32'h0;
    case (bus.ALU_FUN)
      c_ALU_ADD:  w_result = bus.SRC_A + bus.SRC_B;
      c_ALU_SUB:  w_result = bus.SRC_A - bus.SRC_B;
      c_ALU_SLL:  w_result = bus.SRC_A << w_shamt;
      c_ALU_SLT:  w_result = {31'h0, $signed(bus.SRC_A) < $signed(bus.SRC_B)};
      c_ALU_SLTU: w_result = {31'h0, bus.SRC_A < bus.SRC_B};
      c_ALU_XOR:  w_result = bus.SRC_A ^ bus.SRC_B;
      c_ALU_SRL:  w_result = bus.SRC_A >> w_shamt;
      c_ALU_SRA:  w_result = $unsigned($signed(bus.SRC_A) >>> w_shamt);
      c_ALU_OR:   w_result = bus.SRC_A | bus.SRC_B;
      c_ALU_AND:  w_result = bus.SRC_A & bus.SRC_B;
      c_ALU_LUI:  w_result = bus.SRC_A;
      default:    w_result = 32'h0;
    endcase
  end

  // Branch targets wrap modulo 2^32; JALR clears bit 0 of the sum.
  assign w_jalr_sum  = bus.RS1 + bus.I_IMM;
  assign bus.JAL     = bus.PC + bus.J_IMM;
  assign bus.BRANCH  = bus.PC + bus.B_IMM;
  assign bus.JALR    = w_jalr_sum & 32'hFFFF_FFFE;

  assign bus.BR_EQ   = (bus.RS1 == bus.RS2);
  assign bus.BR_LT   = ($signed(bus.RS1) < $signed(bus.RS2));
  assign bus.BR_LTU  = (bus.RS1 < bus.RS2);

  // Falling-edge register to line up with the core's pipeline registers.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      r_result_q <= 32'h0;
    end else if (bus.EN) begin
      r_result_q <= w_result;
    end
  end

  assign bus.RESULT   = w_result;
  assign bus.RESULT_Q = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_otter_exec_unit.sv
`default_nettype none
// ============================================================================
//  tb_otter_exec_unit
//  Directed and random checks of otter_exec_unit against a behavioural model.
//  Revision: 1.0
// ============================================================================
module tb_otter_exec_unit;

  logic CLK;
  logic RST;
  int   n_vec;
  int   n_err;
  logic [31:0] q_model;

  otter_exec_unit_if bus ();

  otter_exec_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    int          sh;
    sh = int'(b % 32);
    case (f)
      4'd0:  return a + b;
      4'd8:  return a + (~b + 32'd1);
      4'd1:  return a * (32'd1 << sh);
      4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a / (32'd1 << sh);
      4'd13: begin
        ext = {{32{a[31]}}, a};
        ext = ext >> sh;
        return ext[31:0];
      end
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd9:  return a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_comb();
    logic [31:0] sum;
    check("RESULT", bus.RESULT, ref_alu(bus.ALU_FUN, bus.SRC_A, bus.SRC_B));
    check("JAL", bus.JAL, bus.PC + bus.J_IMM);
    check("BRANCH", bus.BRANCH, bus.PC + bus.B_IMM);
    sum = bus.RS1 + bus.I_IMM;
    check("JALR", bus.JALR, (sum >> 1) << 1);
    check("BR_EQ", {31'h0, bus.BR_EQ}, {31'h0, bus.RS1 == bus.RS2});
    check("BR_LT", {31'h0, bus.BR_LT}, {31'h0, $signed(bus.RS1) < $signed(bus.RS2)});
    check("BR_LTU", {31'h0, bus.BR_LTU}, {31'h0, bus.RS1 < bus.RS2});
  endtask

  // One cycle: drive after rising edge, check comb, then check register after falling edge.
  task automatic apply(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [31:0] ii, input logic [31:0] bi, input logic [31:0] ji,
                       input logic en);
    @(posedge CLK);
    #1;
    bus.ALU_FUN = f;  bus.SRC_A = a;   bus.SRC_B = b;
    bus.RS1 = rs1;    bus.RS2 = rs2;   bus.PC = pc;
    bus.I_IMM = ii;   bus.B_IMM = bi;  bus.J_IMM = ji;
    bus.EN = en;
    #1;
    check_comb();
    @(negedge CLK);
    #1;
    if (en && RST) q_model = ref_alu(f, a, b);
    check("RESULT_Q", bus.RESULT_Q, q_model);
  endtask

  task automatic alu(input string tag, input logic [3:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    apply(f, a, b, 0, 0, 0, 0, 0, 0, 1'b1);
    check(tag, bus.RESULT, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    q_model = 32'h0;
    RST = 1'b0;
    bus.EN = 1'b1;  bus.ALU_FUN = 4'd9;  bus.SRC_A = 32'hDEAD_BEEF;  bus.SRC_B = 0;
    bus.RS1 = 0;    bus.RS2 = 0;         bus.PC = 0;
    bus.I_IMM = 0;  bus.B_IMM = 0;       bus.J_IMM = 0;

    // Reset holds RESULT_Q at 0 across falling edges even with EN=1.
    @(negedge CLK);
    #1;
    check("reset_q", bus.RESULT_Q, 32'h0);
    check("reset_comb", bus.RESULT, 32'hDEAD_BEEF);
    @(posedge CLK);
    #2;
    RST = 1'b1;

    alu("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu("sub_wrap", 4'b1000, 32'h0, 32'h1, 32'hFFFF_FFFF);
    alu("slt_neg", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu("sltu_big", 4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu("sra4", 4'b1101, 32'h8000_0000, 32'h4, 32'hF800_0000);
    alu("srl4", 4'b0101, 32'h8000_0000, 32'h4, 32'h0800_0000);
    alu("sll_mask", 4'b0001, 32'h8000_0000, 32'h21, 32'h0);
    alu("and", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu("or", 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    alu("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu("lui", 4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0F0_F0F0);
    alu("illegal", 4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0);

    apply(0, 0, 0, 32'h203, 32'h1, 32'h100, 32'h2, 32'h20, 32'hFFFF_FFF8, 1'b1);
    check("jal_dir", bus.JAL, 32'hF8);
    check("branch_dir", bus.BRANCH, 32'h120);
    check("jalr_dir", bus.JALR, 32'h204);

    apply(0, 0, 0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 1'b1);
    check("bcg1", {29'h0, bus.BR_EQ, bus.BR_LT, bus.BR_LTU}, 32'b010);
    apply(0, 0, 0, 32'h7, 32'h7, 0, 0, 0, 0, 1'b1);
    check("bcg2", {29'h0, bus.BR_EQ, bus.BR_LT, bus.BR_LTU}, 32'b100);

    // Load then stall: register must hold.
    apply(4'b0000, 32'h1230, 32'h4, 0, 0, 0, 0, 0, 0, 1'b1);
    check("load", bus.RESULT_Q, 32'h1234);
    apply(4'b0100, 32'hAAAA_5555, 32'h1, 0, 0, 0, 0, 0, 0, 1'b0);
    check("hold", bus.RESULT_Q, 32'h1234);

    // Asynchronous clear mid-cycle.
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("async_rst", bus.RESULT_Q, 32'h0);
    check("rst_comb", bus.RESULT, 32'hAAAA_5554);
    #1;
    RST = 1'b1;
    q_model = 32'h0;
    apply(4'b0100, 32'hAAAA_5555, 32'h1, 0, 0, 0, 0, 0, 0, 1'b0);
    check("after_rst_hold", bus.RESULT_Q, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r1;
      logic [31:0] r2;
      r1 = $urandom;
      r2 = ($urandom_range(0, 7) == 0) ? r1 : $urandom;
      apply(4'($urandom_range(0, 15)), $urandom, $urandom, r1, r2, $urandom,
            $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/otter_exec_unit.md
# otter_exec_unit

Combinational execute-stage datapath for the pipelined RV32I OTTER core, bundling three functions:

- the ALU;
- the branch address generator (BAG), producing JAL/JALR/branch targets;
- the branch condition generator (BCG), producing eq/lt/ltu flags.

It sits between the decode/execute pipeline register and the execute/memory pipeline register. A single registered copy of the ALU result feeds the memory stage and forwarding paths.

## Interface
Parameters: none.

- CLK  in  1  clock; the result register samples on the falling edge, matching the core's pipeline registers
- RST  in  1  asynchronous, active-low reset
- EN  in  1  result-register load enable; deasserted during a stall
- ALU_FUN  in  4  ALU operation select
- SRC_A  in  32  ALU operand A (rs1 or U-immediate, muxed upstream)
- SRC_B  in  32  ALU operand B (rs2, immediate or PC, muxed upstream)
- RS1  in  32  forwarded rs1 value (BCG and JALR base)
- RS2  in  32  forwarded rs2 value (BCG)
- PC  in  32  address of the instruction in execute
- I_IMM  in  32  sign-extended I-type immediate
- B_IMM  in  32  sign-extended B-type immediate
- J_IMM  in  32  sign-extended J-type immediate
- RESULT  out  32  combinational ALU result
- RESULT_Q  out  32  registered ALU result
- JAL  out  32  JAL target
- JALR  out  32  JALR target
- BRANCH  out  32  conditional-branch target
- BR_EQ  out  1  RS1 == RS2
- BR_LT  out  1  RS1 < RS2, signed
- BR_LTU  out  1  RS1 < RS2, unsigned

## Operation
ALU, combinational; A and B are 32 bits; shifts use B[4:0] only.

- 0000 ADD: A+B, modulo 2^32, no carry out
- 1000 SUB: A−B, modulo 2^32
- 0001 SLL: A << B[4:0]
- 0010 SLT: 1 if $signed(A) < $signed(B), else 0; zero-extended
- 0011 SLTU: 1 if A < B unsigned, else 0; zero-extended
- 0100 XOR: A^B
- 0101 SRL: A >> B[4:0], logical
- 1101 SRA: A >>> B[4:0], arithmetic (sign fill)
- 0110 OR: A|B
- 0111 AND: A&B
- 1001 LUI copy: RESULT = A
- Any other code: RESULT = 32'h0

BAG, combinational; all additions are 32-bit and wrap silently.

- JAL = PC + J_IMM
- BRANCH = PC + B_IMM
- JALR = (RS1 + I_IMM) & 32'hFFFF_FFFE, so bit 0 is always 0

BCG, combinational; flags are independent and may be set together.

- BR_EQ = (RS1 == RS2)
- BR_LT = signed compare
- BR_LTU = unsigned compare

Result register:

- RESULT_Q loads RESULT on each falling CLK edge when EN=1.
- RESULT_Q holds its value when EN=0.

## Timing
- RESULT, JAL, JALR, BRANCH and all BR_* flags are purely combinational: zero-cycle latency, no internal state.
- RESULT_Q updates one falling edge after its inputs settle, so latency is half a cycle relative to the rising edge.
- RST low clears RESULT_Q to 0 immediately, independent of CLK.
- While RST is low, RESULT_Q stays 0 and EN is ignored.
- The first load after reset occurs on the first falling edge with RST high and EN=1.
- Reset does not affect the combinational outputs; they track their inputs at all times.
- Deasserting RST coincident with a falling edge must not produce a partial load. That edge may either load or hold; the next edge must load.

## Test plan
- ALU arithmetic and SLT:
  - ADD 32'hFFFF_FFFF + 1 → RESULT = 0
  - SUB 0 − 1 → 32'hFFFF_FFFF
  - SLT −1 vs 1 → 1
  - SLTU 32'hFFFF_FFFF vs 1 → 0
- Shifts with A=32'h8000_0000:
  - SRA by 4 → 32'hF800_0000
  - SRL by 4 → 32'h0800_0000
  - SLL by B=32'h21 (only 1 used) → 0
- Logic and copy:
  - A=32'hF0F0_F0F0, B=32'hFF00_FF00
  - AND → 32'hF000_F000, OR → 32'hFFF0_FFF0, XOR → 32'h0FF0_0FF0
  - LUI copy → 32'hF0F0_F0F0
  - Illegal code 1111 → 0
- BAG:
  - PC=32'h100, J_IMM=−8 → JAL = 32'hF8
  - B_IMM=32'h20 → BRANCH = 32'h120
  - RS1=32'h203, I_IMM=2 → JALR = 32'h204
- BCG:
  - RS1=32'hFFFF_FFFF, RS2=1 → BR_EQ=0, BR_LT=1, BR_LTU=0
  - RS1=RS2=7 → BR_EQ=1, BR_LT=0, BR_LTU=0
- Register behaviour:
  - Load 32'h1234 with EN=1, then EN=0 and change inputs → RESULT_Q holds 32'h1234
  - Pulse RST low mid-cycle → RESULT_Q = 0 before the next edge
